execution_muldiv_unit: RTL



---
 rtl/execution_pkg.sv | 23 ++
 rtl/execution_muldiv_unit_if.sv | 32 +++
 rtl/execution_muldiv_step.sv | 39 +++
 rtl/execution_muldiv_unit.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/execution_pkg.sv
`default_nettype none
// ============================================================================
// Module   : execution_pkg
// Brief    : Shared encodings for the EX-stage multiply/divide unit.
// Revision : 1.0 - initial release
// ============================================================================
package execution_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIXUP = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/execution_muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : execution_muldiv_unit_if
// Brief    : Request/result bundle between the EX stage and the mul/div unit.
// Revision : 1.0 - initial release
// ============================================================================
interface execution_muldiv_unit_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             cancel;
    logic             hi_we;
    logic             lo_we;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, operand_a, operand_b, cancel, hi_we, lo_we,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, operand_a, operand_b, cancel, hi_we, lo_we,
        output busy, done, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/execution_muldiv_step.sv
`default_nettype none
// ============================================================================
// Module   : execution_muldiv_step
// Brief    : One combinational shift-add (multiply) or restoring
//            shift-subtract (divide) iteration on the shared accumulator.
// Revision : 1.0 - initial release
// ============================================================================
module execution_muldiv_step #(
    parameter int WIDTH = 32
) (
    input  wire logic               i_div,
    input  wire logic [2*WIDTH:0]   i_acc,
    input  wire logic [WIDTH-1:0]   i_operand,
    output logic      [2*WIDTH:0]   o_acc
);
    // Multiply: acc = {carry, upper product, multiplier bits still to consume}
    logic [WIDTH-1:0] w_addend;
    logic [WIDTH:0]   w_sum;
    logic [2*WIDTH:0] w_mul_acc;

    assign w_addend  = i_acc[0] ? i_operand : {WIDTH{1'b0}};
    assign w_sum     = i_acc[2*WIDTH:WIDTH] + {1'b0, w_addend};
    assign w_mul_acc = {1'b0, w_sum, i_acc[WIDTH-1:1]};

    // Divide: acc = {partial remainder, dividend bits shifting into quotient}
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH+1:0] w_diff;
    logic             w_fits;
    logic [2*WIDTH:0] w_div_acc;

    assign w_rem_sh  = i_acc[2*WIDTH-1:WIDTH-1];
    assign w_diff    = {1'b0, w_rem_sh} - {2'b00, i_operand};
    assign w_fits    = ~w_diff[WIDTH+1];
    assign w_div_acc = {(w_fits ? w_diff[WIDTH:0] : w_rem_sh), i_acc[WIDTH-2:0], w_fits};

    assign o_acc = i_div ? w_div_acc : w_mul_acc;

endmodule
`default_nettype wire

// File: rtl/execution_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : execution_muldiv_unit
// Brief    : Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Revision : 1.0 - initial release
// ============================================================================
module execution_muldiv_unit
    import execution_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  wire logic              clk,
    input  wire logic              reset,
    execution_muldiv_unit_if.slave bus
);
    localparam logic [1:0] c_ST_IDLE  = 2'(IDLE);
    localparam logic [1:0] c_ST_RUN   = 2'(RUN);
    localparam logic [1:0] c_ST_FIXUP = 2'(FIXUP);
    localparam int         c_CNT_W    = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2*WIDTH:0]   r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_orig_a;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_div_zero;
    logic               r_done;

    // Operand conditioning for a newly accepted request
    logic             w_signed;
    logic             w_is_div;
    logic             w_sign_a;
    logic             w_sign_b;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;

    assign w_signed = ~bus.op[0];
    assign w_is_div = bus.op[1];
    assign w_sign_a = w_signed & bus.operand_a[WIDTH-1];
    assign w_sign_b = w_signed & bus.operand_b[WIDTH-1];
    assign w_mag_a  = w_sign_a ? (~bus.operand_a + 1'b1) : bus.operand_a;
    assign w_mag_b  = w_sign_b ? (~bus.operand_b + 1'b1) : bus.operand_b;

    logic [2*WIDTH:0] w_acc_next;

    execution_muldiv_step #(
        .WIDTH     (WIDTH)
    ) u_step (
        .i_div     (r_is_div),
        .i_acc     (r_acc),
        .i_operand (r_opnd),
        .o_acc     (w_acc_next)
    );

    // Sign correction of the raw magnitude result
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    assign w_prod = r_neg_q ? (~r_acc[2*WIDTH-1:0] + 1'b1) : r_acc[2*WIDTH-1:0];
    assign w_quot = r_neg_q ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_r ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1) : r_acc[2*WIDTH-1:WIDTH];

    always_comb begin
        w_res_hi = w_prod[2*WIDTH-1:WIDTH];
        w_res_lo = w_prod[WIDTH-1:0];
        if (r_is_div && r_div_zero) begin
            w_res_hi = r_orig_a;
            w_res_lo = {WIDTH{1'b1}};
        end else if (r_is_div) begin
            w_res_hi = w_rem;
            w_res_lo = w_quot;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_opnd     <= '0;
            r_orig_a   <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_zero <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.hi_we) r_hi <= bus.operand_a;
                    if (bus.lo_we) r_lo <= bus.operand_a;
                    if (bus.start && !bus.cancel) begin
                        r_state    <= c_ST_RUN;
                        r_cnt      <= '0;
                        r_is_div   <= w_is_div;
                        r_orig_a   <= bus.operand_a;
                        r_neg_q    <= w_sign_a ^ w_sign_b;
                        r_neg_r    <= w_sign_a;
                        r_div_zero <= (bus.operand_b == '0);
                        // Divide seeds the dividend low; multiply seeds the multiplier low
                        r_opnd     <= w_is_div ? w_mag_b : w_mag_a;
                        r_acc      <= {{(WIDTH+1){1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
                    end
                end
                c_ST_RUN: begin
                    if (bus.cancel) begin
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_acc <= w_acc_next;
                        if (r_cnt == c_CNT_LAST) begin
                            r_state <= c_ST_FIXUP;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                c_ST_FIXUP: begin
                    r_state <= c_ST_IDLE;
                    if (!bus.cancel) begin
                        r_hi   <= w_res_hi;
                        r_lo   <= w_res_lo;
                        r_done <= 1'b1;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign bus.busy = (r_state != c_ST_IDLE);
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule
`default_nettype wire
